block_nest_checker: RTL and testbench

//  Streaming keyword checker for the P1 character-stream labs. Consumes one ASCII byte per

---
 rtl/block_nest_checker_pkg.sv | 33 +++
 rtl/block_nest_checker_if.sv | 21 ++
 rtl/block_nest_checker_tokenizer.sv | 56 +++++
 rtl/block_nest_checker.sv | 68 ++++++
 tb/tb_block_nest_checker.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/block_nest_checker_pkg.sv
// Shared tokenizer state encoding, ASCII constants and character helpers
// for the begin/end nesting checker.
package blk_chk_pkg;

    typedef enum logic [3:0] {
        ST_WS,
        ST_B,
        ST_BE,
        ST_BEG,
        ST_BEGI,
        ST_BEGIN,
        ST_E,
        ST_EN,
        ST_END,
        ST_WORD
    } tok_state_e;

    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_D = 8'h64;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
    endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Character-stream input and checker status outputs for block_nest_checker.
interface block_nest_checker_if #(
    parameter int unsigned DEPTH_W = 3
);
    logic [7:0]         in;
    logic               in_valid;
    logic               result;
    logic [DEPTH_W-1:0] depth;
    logic               underflow;
    logic               overflow;

    modport master (
        output in, in_valid,
        input  result, depth, underflow, overflow
    );

    modport slave (
        input  in, in_valid,
        output result, depth, underflow, overflow
    );
endinterface

// File: rtl/block_nest_checker_tokenizer.sv
// Keyword tokenizer: recognises whole words "begin"/"end" and pulses a token
// on the delimiter that terminates them.
module kw_tokenizer
    import blk_chk_pkg::*;
#(
    parameter bit CASE_SENS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       begin_tok,
    output logic       end_tok
);

    tok_state_e state_q, state_d;
    logic [7:0] ch;

    assign ch = CASE_SENS ? in : fold_case(in);

    // Tokens are decoded from the current state and the incoming delimiter so
    // the depth counter can commit on the same edge that samples the delimiter.
    always_comb begin
        state_d   = state_q;
        begin_tok = 1'b0;
        end_tok   = 1'b0;
        if (in_valid) begin
            if (!is_letter(ch)) begin
                state_d   = ST_WS;
                begin_tok = (state_q == ST_BEGIN);
                end_tok   = (state_q == ST_END);
            end else begin
                case (state_q)
                    ST_WS:   state_d = (ch == CH_B) ? ST_B :
                                       (ch == CH_E) ? ST_E : ST_WORD;
                    ST_B:    state_d = (ch == CH_E) ? ST_BE   : ST_WORD;
                    ST_BE:   state_d = (ch == CH_G) ? ST_BEG  : ST_WORD;
                    ST_BEG:  state_d = (ch == CH_I) ? ST_BEGI : ST_WORD;
                    ST_BEGI: state_d = (ch == CH_N) ? ST_BEGIN : ST_WORD;
                    ST_E:    state_d = (ch == CH_N) ? ST_EN   : ST_WORD;
                    ST_EN:   state_d = (ch == CH_D) ? ST_END  : ST_WORD;
                    default: state_d = ST_WORD;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WS;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker: saturating depth counter, sticky
// underflow/overflow flags and a registered "balanced so far" result.
module block_nest_checker
    import blk_chk_pkg::*;
#(
    parameter int unsigned MAX_DEPTH = 7,
    parameter int unsigned DEPTH_W   = 3,
    parameter bit          CASE_SENS = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    block_nest_checker_if.slave bus
);

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    logic               begin_tok, end_tok;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               underflow_q, underflow_d;
    logic               overflow_q, overflow_d;
    logic               result_q, result_d;

    kw_tokenizer #(
        .CASE_SENS (CASE_SENS)
    ) u_tok (
        .clk       (clk),
        .reset     (reset),
        .in        (bus.in),
        .in_valid  (bus.in_valid),
        .begin_tok (begin_tok),
        .end_tok   (end_tok)
    );

    always_comb begin
        depth_d     = depth_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        if (begin_tok) begin
            if (depth_q < MAX_D) depth_d = depth_q + 1'b1;
            else                 overflow_d = 1'b1;
        end
        if (end_tok) begin
            if (depth_q != '0) depth_d = depth_q - 1'b1;
            else               underflow_d = 1'b1;
        end
        result_d = ~underflow_d & ~overflow_d & (depth_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            result_q    <= 1'b1;
        end else begin
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            result_q    <= result_d;
        end
    end

    assign bus.depth     = depth_q;
    assign bus.underflow = underflow_q;
    assign bus.overflow  = overflow_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: word-level reference model compared every
// cycle, plus hand-computed checkpoints, for case-insensitive and case-sensitive builds.
module tb_block_nest_checker;

    localparam int MAXD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_c = 8'h20;
    logic       vld_c = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    block_nest_checker_if #(.DEPTH_W(2)) if0 ();
    block_nest_checker_if #(.DEPTH_W(2)) if1 ();

    assign if0.in = in_c;
    assign if0.in_valid = vld_c;
    assign if1.in = in_c;
    assign if1.in_valid = vld_c;

    block_nest_checker #(.MAX_DEPTH(3), .DEPTH_W(2), .CASE_SENS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    block_nest_checker #(.MAX_DEPTH(3), .DEPTH_W(2), .CASE_SENS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    always #5 clk = ~clk;

    // Reference model: collects whole words and interprets them on the delimiter.
    string m_word [2];
    int    m_depth[2];
    bit    m_under[2];
    bit    m_over [2];
    bit    m_live = 1'b0;

    function automatic bit m_result(input int k);
        return !m_under[k] && !m_over[k] && (m_depth[k] == 0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_word[k] = ""; m_depth[k] = 0; m_under[k] = 0; m_over[k] = 0;
            end else if (vld_c) begin
                byte unsigned c;
                c = in_c;
                if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z")) begin
                    if (k == 0 && c >= "A" && c <= "Z") c = c + 8'd32;
                    m_word[k] = $sformatf("%s%c", m_word[k], c);
                end else begin
                    if (m_word[k] == "begin") begin
                        if (m_depth[k] < MAXD) m_depth[k]++; else m_over[k] = 1;
                    end else if (m_word[k] == "end") begin
                        if (m_depth[k] > 0) m_depth[k]--; else m_under[k] = 1;
                    end
                    m_word[k] = "";
                end
            end
        end
        if (reset) m_live = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("dut0 result",    int'(if0.result),    int'(m_result(0)));
            check("dut0 depth",     int'(if0.depth),     m_depth[0]);
            check("dut0 underflow", int'(if0.underflow), int'(m_under[0]));
            check("dut0 overflow",  int'(if0.overflow),  int'(m_over[0]));
            check("dut1 result",    int'(if1.result),    int'(m_result(1)));
            check("dut1 depth",     int'(if1.depth),     m_depth[1]);
            check("dut1 underflow", int'(if1.underflow), int'(m_under[1]));
            check("dut1 overflow",  int'(if1.overflow),  int'(m_over[1]));
        end
    end

    task automatic send(input byte unsigned c);
        in_c = c; vld_c = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        vld_c = 1'b0;
    endtask

    task automatic idle(input int n);
        in_c = "z"; vld_c = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vld_c = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // State pinned against hand-computed values: {result, depth, underflow, overflow}.
    task automatic lit(input string name, input int k, input int r, input int d,
                       input int u, input int o);
        if (k == 0) begin
            check({name, " result"}, int'(if0.result), r);
            check({name, " depth"},  int'(if0.depth), d);
            check({name, " under"},  int'(if0.underflow), u);
            check({name, " over"},   int'(if0.overflow), o);
        end else begin
            check({name, " result"}, int'(if1.result), r);
            check({name, " depth"},  int'(if1.depth), d);
            check({name, " under"},  int'(if1.underflow), u);
            check({name, " over"},   int'(if1.overflow), o);
        end
    endtask

    initial begin
        do_reset();
        lit("reset", 0, 1, 0, 0, 0);
        lit("reset cs", 1, 1, 0, 0, 0);

        // 1: basic begin/end
        send_str("begin");
        lit("t1 no tentative", 0, 1, 0, 0, 0);
        send_str(" ");
        lit("t1 after begin", 0, 0, 1, 0, 0);
        lit("t1 cs after begin", 1, 0, 1, 0, 0);
        check("model t1 depth", m_depth[0], 1);
        send_str("end ");
        lit("t1 after end", 0, 1, 0, 0, 0);

        // 2: mixed case with ';' delimiter
        do_reset();
        send_str("BeGiN ");
        lit("t2 after begin", 0, 0, 1, 0, 0);
        lit("t2 cs ignored", 1, 1, 0, 0, 0);
        send_str("eNd;");
        lit("t2 after end", 0, 1, 0, 0, 0);
        lit("t2 cs still", 1, 1, 0, 0, 0);

        // 3: keyword-prefixed words and sticky underflow
        do_reset();
        send_str("beginx endc end ");
        lit("t3 underflow", 0, 0, 0, 1, 0);
        check("model t3 under", int'(m_under[0]), 1);
        send_str("begin ");
        lit("t3 depth up", 0, 0, 1, 1, 0);
        send_str("end ");
        lit("t3 sticky", 0, 0, 0, 1, 0);

        // 4: overflow saturation
        do_reset();
        send_str("begin begin begin ");
        lit("t4 at max", 0, 0, 3, 0, 0);
        send_str("begin ");
        lit("t4 overflow", 0, 0, 3, 0, 1);
        send_str("end end end ");
        lit("t4 back to 0", 0, 0, 0, 0, 1);

        // 5: in_valid gap mid-word
        do_reset();
        send_str("be");
        idle(3);
        lit("t5 gap", 0, 1, 0, 0, 0);
        send_str("gin ");
        lit("t5 after gap", 0, 0, 1, 0, 0);

        // 6: reset mid-word discards the prefix
        do_reset();
        send_str("begi");
        do_reset();
        send_str("n end ");
        lit("t6 underflow", 0, 0, 0, 1, 0);

        // 7: reset wins over a valid terminating delimiter
        do_reset();
        send_str("begin");
        in_c = " "; vld_c = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; vld_c = 1'b0;
        lit("t7 reset wins", 0, 1, 0, 0, 0);
        send_str("end1");
        lit("t7 digit delim", 0, 0, 0, 1, 0);

        // stream ending mid-word: nothing committed
        do_reset();
        send_str("begin begin en");
        idle(2);
        lit("t8 pending", 0, 0, 2, 0, 0);
        send_str("d\t");
        lit("t8 commit", 0, 0, 1, 0, 0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
